// File: rtl/bec_ladder_core.sv
// bec_ladder_core: BEC w-coordinate Montgomery ladder over GF(2^163)
// built around one shared MSB-first bit-serial field multiplier.
module bec_ladder_core #(
  parameter int NBITS = 163
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic         master_ena_proc,
  input  logic         ki,
  input  logic [162:0] w1,
  input  logic [162:0] z1,
  input  logic [162:0] w2,
  input  logic [162:0] z2,
  input  logic [162:0] inv_w0,
  input  logic [162:0] d,
  output logic         slv_done,
  output logic         next_key,
  output logic [162:0] wout,
  output logic [162:0] zout
);

  localparam int SW = $clog2(NBITS + 1);
  localparam logic [SW-1:0] LAST = SW'(NBITS - 1);
  localparam logic [162:0] POLY = 163'hC9;

  typedef logic [162:0] fe_t;
  typedef enum logic [2:0] {
    IDLE, LOAD, MSTART, MRUN, WB, DONE
  } state_t;

  state_t state_q, state_d;
  logic [3:0] op_q, op_d;
  logic [7:0] bit_q, bit_d;
  logic [SW-1:0] step_q, step_d;
  logic sel_q, sel_d;
  logic done_q, done_d;
  logic nk_q, nk_d;
  fe_t wa_q, wa_d, za_q, za_d;
  fe_t wb_q, wb_d, zb_q, zb_d;
  fe_t iw_q, iw_d, dd_q, dd_d;
  fe_t c_q, c_d, s_q, s_d, t_q, t_d;
  fe_t u_q, u_d, v_q, v_d;
  fe_t w4_q, w4_d, z4_q, z4_d;
  fe_t w5_q, w5_d, z5_q, z5_d;
  fe_t ma_q, ma_d, mb_q, mb_d;
  fe_t acc_q, acc_d;
  fe_t wout_q, wout_d, zout_q, zout_d;

  fe_t acc_sh, prod;
  fe_t wd, zd, wo, zo;
  logic sel_e;

  // one multiplier bit: acc*x mod f, then add a if b bit set
  always_comb begin
    acc_sh = {acc_q[161:0], 1'b0} ^ (acc_q[162] ? POLY : '0);
    prod = acc_sh ^ (mb_q[bit_q] ? ma_q : '0);
  end

  // doubled/other point select; op1 uses the live key bit
  always_comb begin
    sel_e = (op_q == 4'd0) ? ki : sel_q;
    wd = sel_e ? wb_q : wa_q;
    zd = sel_e ? zb_q : za_q;
    wo = sel_e ? wa_q : wb_q;
    zo = sel_e ? za_q : zb_q;
  end

  // ladder sequencer and datapath next-state
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    bit_d = bit_q;
    step_d = step_q;
    sel_d = sel_q;
    done_d = done_q;
    nk_d = 1'b0;
    wa_d = wa_q;
    za_d = za_q;
    wb_d = wb_q;
    zb_d = zb_q;
    iw_d = iw_q;
    dd_d = dd_q;
    c_d = c_q;
    s_d = s_q;
    t_d = t_q;
    u_d = u_q;
    v_d = v_q;
    w4_d = w4_q;
    z4_d = z4_q;
    w5_d = w5_q;
    z5_d = z5_q;
    ma_d = ma_q;
    mb_d = mb_q;
    acc_d = acc_q;
    wout_d = wout_q;
    zout_d = zout_q;
    unique case (state_q)
      IDLE: begin
        if (master_ena_proc) state_d = LOAD;
      end
      LOAD: begin
        if (!master_ena_proc) begin
          state_d = IDLE;
        end else begin
          wa_d = w1;
          za_d = z1;
          wb_d = w2;
          zb_d = z2;
          iw_d = inv_w0;
          dd_d = d;
          step_d = '0;
          op_d = 4'd0;
          state_d = MSTART;
        end
      end
      MSTART: begin
        if (!master_ena_proc) begin
          state_d = IDLE;
        end else begin
          acc_d = '0;
          bit_d = 8'd162;
          state_d = MRUN;
          if (op_q == 4'd0) sel_d = ki;
          case (op_q)
            4'd0: begin ma_d = wd; mb_d = zd ^ wd; end
            4'd1: begin ma_d = zd; mb_d = zd; end
            4'd2: begin ma_d = s_q; mb_d = s_q; end
            4'd3: begin ma_d = dd_q; mb_d = s_q; end
            4'd4: begin ma_d = c_q; mb_d = c_q; end
            4'd5: begin ma_d = wo; mb_d = zo ^ wo; end
            4'd6: begin ma_d = c_q; mb_d = t_q; end
            4'd7: begin ma_d = zd; mb_d = zo; end
            4'd8: begin ma_d = u_q; mb_d = u_q; end
            4'd9: begin ma_d = dd_q; mb_d = u_q; end
            4'd10: begin ma_d = z5_q; mb_d = iw_q; end
            default: begin ma_d = ma_q; mb_d = mb_q; end
          endcase
        end
      end
      MRUN: begin
        if (!master_ena_proc) begin
          state_d = IDLE;
        end else begin
          acc_d = prod;
          bit_d = bit_q - 8'd1;
          if (bit_q == 8'd0) begin
            case (op_q)
              4'd0: c_d = prod;
              4'd1, 4'd2, 4'd3: s_d = prod;
              4'd4: begin w4_d = prod; z4_d = prod ^ s_q; end
              4'd5: t_d = prod;
              4'd6: v_d = prod;
              4'd7, 4'd8: u_d = prod;
              4'd9: begin u_d = prod; z5_d = v_q ^ prod; end
              4'd10: w5_d = v_q ^ prod;
              default: c_d = c_q;
            endcase
            if (op_q == 4'd10) begin
              state_d = WB;
              nk_d = 1'b1;
            end else begin
              op_d = op_q + 4'd1;
              state_d = MSTART;
            end
          end
        end
      end
      WB: begin
        if (!master_ena_proc) begin
          state_d = IDLE;
        end else begin
          if (sel_q) begin
            wb_d = w4_q;
            zb_d = z4_q;
            wa_d = w5_q;
            za_d = z5_q;
          end else begin
            wa_d = w4_q;
            za_d = z4_q;
            wb_d = w5_q;
            zb_d = z5_q;
          end
          step_d = step_q + SW'(1);
          op_d = 4'd0;
          if (step_q == LAST) begin
            state_d = DONE;
            done_d = 1'b1;
            wout_d = wa_d;
            zout_d = za_d;
          end else begin
            state_d = MSTART;
          end
        end
      end
      DONE: begin
        if (!master_ena_proc) begin
          state_d = IDLE;
          done_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // all state registers, cleared by async reset
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q <= IDLE;
      op_q <= '0;
      bit_q <= '0;
      step_q <= '0;
      sel_q <= 1'b0;
      done_q <= 1'b0;
      nk_q <= 1'b0;
      wa_q <= '0;
      za_q <= '0;
      wb_q <= '0;
      zb_q <= '0;
      iw_q <= '0;
      dd_q <= '0;
      c_q <= '0;
      s_q <= '0;
      t_q <= '0;
      u_q <= '0;
      v_q <= '0;
      w4_q <= '0;
      z4_q <= '0;
      w5_q <= '0;
      z5_q <= '0;
      ma_q <= '0;
      mb_q <= '0;
      acc_q <= '0;
      wout_q <= '0;
      zout_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      bit_q <= bit_d;
      step_q <= step_d;
      sel_q <= sel_d;
      done_q <= done_d;
      nk_q <= nk_d;
      wa_q <= wa_d;
      za_q <= za_d;
      wb_q <= wb_d;
      zb_q <= zb_d;
      iw_q <= iw_d;
      dd_q <= dd_d;
      c_q <= c_d;
      s_q <= s_d;
      t_q <= t_d;
      u_q <= u_d;
      v_q <= v_d;
      w4_q <= w4_d;
      z4_q <= z4_d;
      w5_q <= w5_d;
      z5_q <= z5_d;
      ma_q <= ma_d;
      mb_q <= mb_d;
      acc_q <= acc_d;
      wout_q <= wout_d;
      zout_q <= zout_d;
    end
  end

  // a step dropped by an abort in WB must not shift the key
  assign next_key = nk_q & master_ena_proc;
  assign slv_done = done_q;
  assign wout = wout_q;
  assign zout = zout_q;

endmodule

// File: doc/bec_ladder_core.md
# bec_ladder_core

Binary Edwards curve (BEC) w-coordinate Montgomery-ladder engine over GF(2^163). It sits directly downstream of the LA-driven operand controller. On `master_ena_proc` it latches the two ladder points (w1,z1)/(w2,z2) plus `inv_w0` and `d`. It then consumes one key bit per step from `ki`, requesting the next bit with `next_key`. It returns the final projective point on `wout`/`zout` with `slv_done`. All field arithmetic runs on a single bit-serial multiplier driven by a fixed 11-operation microsequence.

## Interface
- NBITS, 163: ladder steps per run (key length); benches may lower it.
- wb_clk_i  in  1  clock; all state on rising edge.
- wb_rst_i  in  1  asynchronous, active-low reset (0 = reset).
- master_ena_proc  in  1  run request; level, held high for the whole run.
- ki  in  1  current key bit; sampled at the start of each step.
- w1, z1, w2, z2  in  163 each  initial points A=(w1,z1), B=(w2,z2); latched at start.
- inv_w0, d  in  163 each  difference-point term and curve constant; latched at start.
- slv_done  out  1  result valid; level.
- next_key  out  1  one-cycle pulse per completed step.
- wout, zout  out  163 each  final A coordinates.

## Operation
- Field: GF(2^163), f = x^163+x^7+x^6+x^3+1. Addition is XOR.
- Multiplier: MSB-first bit-serial. Per bit: acc ← (acc·x mod f) XOR (b[i] ? a : 0).
- Registers:
  - Working: Wa, Za, Wb, Zb, IW, D.
  - Temps: C, S, T, U, V, W4, Z4.
- FSM states: IDLE, LOAD, MSTART, MRUN, WB, DONE.
- IDLE → LOAD when master_ena_proc=1. LOAD latches all operands, clears step counter and op index, then → MSTART.
- Each step, at op1 MSTART, latch sel=ki:
  - ki=0: doubled (Wd,Zd)=A, other (Wo,Zo)=B.
  - ki=1: doubled (Wd,Zd)=B, other (Wo,Zo)=A.
- Microsequence (one multiply each):
  - op1: C=Wd·(Zd+Wd)
  - op2: S=Zd·Zd
  - op3: S=S·S
  - op4: S=D·S
  - op5: W4=C·C; Z4=W4+S
  - op6: T=Wo·(Zo+Wo)
  - op7: V=C·T
  - op8: U=Zd·Zo
  - op9: U=U·U
  - op10: U=D·U; Z5=V+U
  - op11: W5=V+Z5·IW
- WB: doubled ← (W4,Z4), other ← (W5,Z5); assert next_key; increment counter.
- After WB: if counter==NBITS → DONE (load wout=Wa, zout=Za), else → op1 MSTART.
- DONE: hold slv_done=1, wout/zout stable, until master_ena_proc=0, then → IDLE.
- master_ena_proc=0 in LOAD/MSTART/MRUN/WB: abort to IDLE next cycle. No next_key, no slv_done, wout/zout unchanged.

## Timing
- Reset values:
  - slv_done=0, next_key=0, wout=0, zout=0.
  - All working and temp registers 0; state IDLE.
- Multiply: MSTART 1 cycle (load operands, clear acc) + MRUN 163 cycles = 164 cycles. Result is written at the last MRUN edge.
- Step = 11×164 + 1 (WB) = 1805 cycles.
- Latency: from the edge sampling master_ena_proc=1 to the first cycle slv_done=1 is 1 + NBITS·1805 cycles (294216 for NBITS=163).
- next_key:
  - Exactly NBITS pulses per run, each in the WB cycle.
  - The upstream shift lands on that same edge, so ki is valid at the next op1 MSTART.
- ki is ignored outside op1 MSTART.
- slv_done rises in the same cycle wout/zout update. It falls the cycle after master_ena_proc is sampled low.
- Re-run: master_ena_proc high again in IDLE starts a fresh LOAD. There is no minimum idle gap beyond the single IDLE cycle.
- Reset assertion mid-run: immediate return to reset values, regardless of state.

## Test plan
- Reset: drive wb_rst_i=0 mid-MRUN → all outputs 0 same cycle. Release → IDLE, no slv_done without a new request.
- NBITS=1, ki=0, w1=w2=0x2, z1=z2=0x1, d=0x1, inv_w0=0x1 → slv_done after 1806 cycles, wout=0x14, zout=0x15, one next_key pulse.
- NBITS=1, ki=1, (w1,z1)=(0x1,0x0), (w2,z2)=(0x2,0x1), d=0x1, inv_w0=0x1 → wout=0x0, zout=0x6.
- Reduction: 200 random runs, NBITS=4, operands with bit 162 set, random ki stream → wout/zout match the bench GF(2^163) golden model using the same microsequence.
- Handshake: hold master_ena_proc high 50 cycles past slv_done → slv_done and wout/zout stable. Drop it → slv_done=0 next cycle. Count exactly NBITS next_key pulses.
- Abort: drop master_ena_proc at op7 of step 2 → IDLE next cycle, no further next_key, slv_done stays 0, wout/zout keep their previous values.
